// File: rtl/decrypt_stage_1.sv
// decrypt_stage_1 -- two-stage valid/ready decryptor for the stage-1 encryptor.
// Unpacks {rand_11, x, rand_6}, rebuilds the 60-bit mask from rand_11,
// subtracts it from x and flags/counts words whose payload is below the mask.
// Optional build macro: DECRYPT_STAGE_1_DROP_BAD_EN -- when defined, malformed
// words are counted and then discarded instead of being presented.
module decrypt_stage_1 #(
  parameter int ERR_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [77:0]      in_enc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [59:0]      out_data,
  output logic [5:0]       out_tag,
  output logic             out_err,
  output logic [ERR_W-1:0] err_count
);

  // Mask segments 2 and 3 (bits [32:22] and [43:33]) carry the inverted key.
  localparam logic [4:0] SEG_INV = 5'b01100;

  // Stage S1 (capture) state
  logic        s1_valid_reg;
  logic [10:0] s1_key_reg;
  logic [60:0] s1_x_reg;
  logic [5:0]  s1_tag_reg;

  // Stage S2 (output) state
  logic             out_valid_reg;
  logic [59:0]      out_data_reg;
  logic [5:0]       out_tag_reg;
  logic [ERR_W-1:0] err_count_reg;
  logic [ERR_W-1:0] err_count_next;

  // Datapath
  logic [54:0] mask_low;
  logic [59:0] mask;
  logic [60:0] diff;
  logic        borrow;
  logic        malformed;

  // Flow control
  logic s2_adv;
  logic s1_adv;
  logic in_xfer;
  logic s2_load;
  logic s2_keep;

  // Five full 11-bit key copies make up mask[54:0]; the top 5 bits reuse key[4:0].
  for (genvar gi = 0; gi < 5; gi++) begin : g_mask_seg
    assign mask_low[gi*11 +: 11] = SEG_INV[gi] ? ~s1_key_reg : s1_key_reg;
  end
  assign mask = {s1_key_reg[4:0], mask_low};

  // 62-bit subtraction: bit 61 is the borrow, diff wraps modulo 2^61.
  assign {borrow, diff} = {1'b0, s1_x_reg} - {2'b00, mask};
  assign malformed      = borrow | diff[60];

  assign s2_adv   = ~out_valid_reg | out_ready;
  assign s1_adv   = ~s1_valid_reg | s2_adv;
  assign in_ready = s1_adv;
  assign in_xfer  = in_valid & s1_adv;
  assign s2_load  = s2_adv & s1_valid_reg;

`ifdef DECRYPT_STAGE_1_DROP_BAD_EN
  // A malformed word frees its slot instead of occupying S2.
  assign s2_keep = s1_valid_reg & ~malformed;
`else
  assign s2_keep = s1_valid_reg;
`endif

  // Saturating malformed-word count, bumped when a bad word reaches S2.
  always_comb begin
    err_count_next = err_count_reg;
    if (s2_load && malformed && (err_count_reg != {ERR_W{1'b1}})) begin
      err_count_next = err_count_reg + ERR_W'(1);
    end
  end

  // S1: capture on input transfer, otherwise empty out when S2 takes the word.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_valid_reg <= 1'b0;
      s1_key_reg   <= '0;
      s1_x_reg     <= '0;
      s1_tag_reg   <= '0;
    end else if (in_xfer) begin
      s1_valid_reg <= 1'b1;
      s1_key_reg   <= in_enc[77:67];
      s1_x_reg     <= in_enc[66:6];
      s1_tag_reg   <= in_enc[5:0];
    end else if (s2_adv) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // S2: advance when the sink is free; payload only changes when a word is kept.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_tag_reg   <= '0;
      err_count_reg <= '0;
    end else begin
      err_count_reg <= err_count_next;
      if (s2_adv) begin
        out_valid_reg <= s2_keep;
        if (s2_keep) begin
          out_data_reg <= diff[59:0];
          out_tag_reg  <= s1_tag_reg;
        end
      end
    end
  end

`ifdef DECRYPT_STAGE_1_DROP_BAD_EN
  // Malformed words never reach the output, so the flag is constant.
  assign out_err = 1'b0;
`else
  logic out_err_reg;

  // Error flag travels with the word it describes.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_err_reg <= 1'b0;
    end else if (s2_adv && s2_keep) begin
      out_err_reg <= malformed;
    end
  end

  assign out_err = out_err_reg;
`endif

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_tag   = out_tag_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_decrypt_stage_1.sv
// tb_decrypt_stage_1 -- directed + random bench for decrypt_stage_1.
// A second instance with ERR_W=4 shares the stimulus to observe saturation.
`timescale 1ns/1ps
module tb_decrypt_stage_1;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [77:0] in_enc = '0;

  logic        in_ready, out_valid, out_err;
  logic [59:0] out_data;
  logic [5:0]  out_tag;
  logic [15:0] err_count;

  logic        s_in_ready, s_out_valid, s_out_err;
  logic [59:0] s_out_data;
  logic [5:0]  s_out_tag;
  logic [3:0]  s_err_count;

  decrypt_stage_1 dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready), .in_enc(in_enc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_err(out_err), .err_count(err_count)
  );

  decrypt_stage_1 #(.ERR_W(4)) dut_small (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_enc(in_enc),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_tag(s_out_tag),
    .out_err(s_out_err), .err_count(s_err_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [59:0] data;
    logic [5:0]  tag;
    logic        err;
    int          cum;   // malformed words accepted up to and including this one
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int bad_total = 0;
  int stall_cycles = 0;
  int out_count = 0;
  bit mixed_done = 0;

`ifdef DECRYPT_STAGE_1_DROP_BAD_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  // Mask written straight from the bit-field table.
  function automatic logic [59:0] mask_of(input logic [10:0] k);
    logic [59:0] m;
    m[10:0]  = k;
    m[21:11] = k;
    m[32:22] = ~k;
    m[43:33] = ~k;
    m[54:44] = k;
    m[59:55] = k[4:0];
    return m;
  endfunction

  // Reference stage-1 encryptor.
  function automatic logic [77:0] encrypt(input logic [59:0] d, input logic [10:0] r11,
                                          input logic [5:0] r6);
    logic [60:0] x;
    x = {1'b0, d} + {1'b0, mask_of(r11)};
    return {r11, x, r6};
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of an accepted word: signed arithmetic on the unpacked fields.
  task automatic accept(input logic [77:0] w);
    longint xs, bs, diff;
    bit     bad;
    exp_t   e;
    xs   = longint'({3'b000, w[66:6]});
    bs   = longint'({4'b0000, mask_of(w[77:67])});
    diff = xs - bs;
    bad  = (diff < 0) || (diff >= (64'sd1 <<< 60));
    if (bad) bad_total++;
    e.data = diff[59:0];
    e.tag  = w[5:0];
    e.err  = bad;
    e.cum  = bad_total;
    if (!(DROP && bad)) q.push_back(e);
  endtask

  // Compare process: checks DUT outputs against the model every cycle.
  logic        prev_stall = 1'b0;
  logic [59:0] prev_data;
  logic [5:0]  prev_tag;
  logic        prev_err;
  always @(negedge Clk) begin
    if (Rst) begin
      q.delete();
      bad_total  = 0;
      prev_stall = 1'b0;
    end else begin
      if (!DROP) begin
        chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
        chk("small_in_ready", s_in_ready, !(q.size() == 2 && !out_ready));
      end
      if (prev_stall) begin
        chk("stall_data_stable", out_data, prev_data);
        chk("stall_tag_stable", out_tag, prev_tag);
        chk("stall_err_stable", out_err, prev_err);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 1'b0);
        end else begin
          chk("out_data", out_data, q[0].data);
          chk("out_tag", out_tag, q[0].tag);
          chk("out_err", out_err, DROP ? 1'b0 : q[0].err);
          chk("err_count", err_count, sat(q[0].cum, 16));
        end
      end
      if (s_out_valid) begin
        if (q.size() == 0) begin
          chk("small_spurious_out_valid", s_out_valid, 1'b0);
        end else begin
          chk("small_out_data", s_out_data, q[0].data);
          chk("small_err_count", s_err_count, sat(q[0].cum, 4));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_tag   = out_tag;
      prev_err   = out_err;
      if (out_valid && out_ready && q.size() > 0) begin
        void'(q.pop_front());
        out_count++;
      end
      if (in_valid && in_ready) accept(in_enc);
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Present a word and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [77:0] w);
    int n;
    bit done;
    in_valid = 1'b1;
    in_enc   = w;
    n        = 0;
    done     = 0;
    while (!done) begin
      @(negedge Clk);
      if (in_ready) begin
        done = 1;
      end else begin
        n++;
        stall_cycles++;
        if (n > 1000) begin
          chk("send_timeout", 64'd0, 64'd1);
          in_valid = 1'b0;
          return;
        end
      end
    end
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge Clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    step();
  endtask

  task automatic pulse_reset();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
  endtask

  logic [77:0] w1, w2, w3;
  logic [63:0] r;
  int          out_before, stall_before;

  initial begin
    w1 = encrypt(60'hABC, 11'h7FF, 6'h01);
    w2 = encrypt(60'hFFF_FFFF_FFFF_FFFF, 11'h123, 6'h02);
    w3 = encrypt(60'h0, 11'h400, 6'h3F);

    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_small_err_count", s_err_count, 0);
    chk("rst_in_ready", in_ready, 1);

    // Good word: visible after the second edge counting the capture edge.
    step();
    out_ready = 1'b1;
    send({11'h000, 61'h0FFF_FFC0_0005, 6'h2A});
    @(negedge Clk);
    chk("good_not_yet_valid", out_valid, 0);
    @(negedge Clk);
    chk("good_out_valid", out_valid, 1);
    chk("good_out_data", out_data, 60'h5);
    chk("good_out_tag", out_tag, 6'h2A);
    chk("good_out_err", out_err, 0);
    chk("good_err_count", err_count, 0);
    repeat (3) step();

    // Malformed: key=0, x=0.
    send({11'h000, 61'h0, 6'h11});
    @(negedge Clk);
    @(negedge Clk);
    if (DROP) begin
      chk("bad_dropped_no_valid", out_valid, 0);
      chk("bad_dropped_err_count", err_count, 1);
      step();
      send(encrypt(60'h123, 11'h5A5, 6'h03));
      @(negedge Clk);
      @(negedge Clk);
      chk("after_drop_valid", out_valid, 1);
      chk("after_drop_data", out_data, 60'h123);
      chk("after_drop_err_count", err_count, 1);
    end else begin
      chk("bad_out_valid", out_valid, 1);
      chk("bad_out_err", out_err, 1);
      chk("bad_out_data", out_data, 60'hFFF_F000_0040_0000);
      chk("bad_err_count", err_count, 1);
    end
    repeat (4) step();

    // Backpressure: two words fill the pipe, third waits.
    out_before = out_count;
    out_ready  = 1'b0;
    send(w1);
    send(w2);
    in_valid = 1'b1;
    in_enc   = w3;
    @(negedge Clk);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_head_data", out_data, 60'hABC);
    repeat (3) begin
      @(negedge Clk);
      chk("bp_in_ready_held", in_ready, 0);
    end
    step();
    out_ready = 1'b1;
    send(w3);
    drain();
    chk("bp_three_out", out_count - out_before, 3);

    // Reset mid-stream with err_count=5 and both stages full.
    pulse_reset();
    for (int i = 0; i < 5; i++) send({11'h000, 61'(i), 6'(i)});
    repeat (4) step();
    chk("pre_rst_err_count", err_count, 5);
    out_ready = 1'b0;
    send(w1);
    send(w2);
    Rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_enc    = w3;
    step();
    Rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge Clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_tag", out_tag, 0);
    chk("mid_rst_out_err", out_err, 0);
    chk("mid_rst_err_count", err_count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    repeat (5) begin
      @(negedge Clk);
      chk("no_stale_word", out_valid, 0);
    end

    // Saturation: 20 malformed words.
    step();
    for (int i = 0; i < 20; i++) send({11'h000, 61'(i + 1), 6'(i)});
    repeat (4) step();
    chk("sat_small_err_count", s_err_count, 4'hF);
    chk("sat_main_err_count", err_count, 20);

    // Mixed random traffic with random backpressure.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          r = {$urandom(), $urandom()};
          if ($urandom_range(0, 7) == 0)
            send({11'($urandom()), r[60:0], 6'($urandom())});
          else
            send(encrypt(r[59:0], 11'($urandom()), 6'($urandom())));
        end
        mixed_done = 1;
      end
      begin
        while (!mixed_done) begin
          step();
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Round trip stream at full rate.
    pulse_reset();
    stall_before = stall_cycles;
    for (int i = 0; i < 10000; i++) begin
      r = {$urandom(), $urandom()};
      send(encrypt(r[59:0], 11'($urandom()), 6'($urandom())));
    end
    drain();
    chk("stream_stalls", stall_cycles - stall_before, 0);
    chk("stream_err_count", err_count, sat(bad_total, 16));
    chk("stream_err_zero", err_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
